// File: rtl/psum_collector_if.sv
// rtl/psum_collector_if.sv - psum input and writeback stream bundle for psum_collector
// The collector uses the slave modport. The driver of the psum chain and the writeback path uses master.
interface psum_collector_if #(
  parameter int PSUM_WIDTH = 32
);
  logic [PSUM_WIDTH-1:0] psum_i;
  logic                  psum_en_i;
  logic [PSUM_WIDTH-1:0] out_data_o;
  logic                  out_last_o;
  logic                  out_valid_o;
  logic                  out_ready_i;

  modport slave (
    input  psum_i, psum_en_i, out_ready_i,
    output out_data_o, out_last_o, out_valid_o
  );

  modport master (
    output psum_i, psum_en_i, out_ready_i,
    input  out_data_o, out_last_o, out_valid_o
  );
endinterface

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - PE column psum drain FIFO with tile-last tagging and valid/ready output
// Optional PSUM_COLLECT_RELU_EN clamps negative psums to zero at write time.
module psum_collector #(
  parameter int PSUM_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int TILE_LEN   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  psum_collector_if.slave        bus,
  input  logic                   clear_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [TW-1:0]         tile_q, tile_d;
  logic                  overflow_q, overflow_d;
  logic [PSUM_WIDTH:0]   mem_q [DEPTH];
  logic [PSUM_WIDTH:0]   wr_entry_d;
  logic [PSUM_WIDTH:0]   head;
  logic [PSUM_WIDTH-1:0] wr_data;
  logic                  not_empty, full, pop, push_req, wr_en, tile_last;

  always_comb begin
`ifdef PSUM_COLLECT_RELU_EN
    wr_data = bus.psum_i[PSUM_WIDTH-1] ? '0 : bus.psum_i;
`else
    wr_data = bus.psum_i;
`endif
  end

  always_comb begin
    not_empty  = (count_q != '0);
    full       = (count_q == CW'(DEPTH));
    pop        = not_empty && bus.out_ready_i;
    push_req   = bus.psum_en_i && !clear_i;
    // A slot freed by a same-cycle pop makes room even when full.
    wr_en      = push_req && (!full || pop);
    tile_last  = (tile_q == TW'(TILE_LEN - 1));
    wr_entry_d = {tile_last, wr_data};

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tile_d     = tile_q;
    overflow_d = overflow_q;

    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      tile_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !pop)      count_d = count_q + CW'(1);
      else if (pop && !wr_en) count_d = count_q - CW'(1);
      // Dropped psums still advance the tile position so later tiles stay aligned.
      if (push_req) tile_d = tile_last ? '0 : tile_q + TW'(1);
      if (push_req && !wr_en) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tile_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tile_q     <= tile_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry_d;
  end

  always_comb begin
    head            = mem_q[rd_ptr_q];
    bus.out_valid_o = not_empty;
    bus.out_data_o  = not_empty ? head[PSUM_WIDTH-1:0] : '0;
    bus.out_last_o  = not_empty && head[PSUM_WIDTH];
    count_o         = count_q;
    full_o          = full;
    overflow_o      = overflow_q;
  end
endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - table-driven and scoreboard bench for psum_collector
// Default parameters (32-bit, DEPTH 8, TILE_LEN 16). Honours PSUM_COLLECT_RELU_EN.
module tb_psum_collector;
  logic       clk;
  logic       rst;
  logic       clear_i;
  logic [3:0] count_o;
  logic       full_o;
  logic       overflow_o;

  psum_collector_if #(.PSUM_WIDTH(32)) bus ();

  psum_collector #(.PSUM_WIDTH(32), .DEPTH(8), .TILE_LEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clear_i    (clear_i),
    .count_o    (count_o),
    .full_o     (full_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] psum;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    logic [3:0]  e_count;
    logic        e_full;
    logic        e_ovf;
  } vec_t;

  vec_t        tbl[$];
  logic [32:0] m_q[$];
  int          m_tile;
  logic        m_ovf;
  logic [31:0] last_vals[$];
  logic [31:0] last_popped;
  int          n_chk;
  int          n_err;

  function automatic logic [31:0] m_relu(input logic [31:0] x);
`ifdef PSUM_COLLECT_RELU_EN
    return x[31] ? 32'h0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [31:0] psum, input logic rdy, input logic clr,
                     input logic ev, input logic [31:0] ed, input logic el, input int ec,
                     input logic ef, input logic eo);
    vec_t v;
    v.en = en; v.psum = psum; v.rdy = rdy; v.clr = clr;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_count = 4'(ec); v.e_full = ef; v.e_ovf = eo;
    tbl.push_back(v);
  endtask

  // Called just after a falling edge: check the current state against the model, drive, then advance one cycle.
  task automatic drive(input logic en, input logic [31:0] psum, input logic rdy, input logic clr);
    logic        was_full;
    logic        m_pop;
    logic        lst;
    logic [32:0] dummy;
    chk("valid", 64'(bus.out_valid_o), 64'(m_q.size() != 0));
    chk("count", 64'(count_o), 64'(m_q.size()));
    chk("full", 64'(full_o), 64'(m_q.size() == 8));
    chk("ovf", 64'(overflow_o), 64'(m_ovf));
    if (m_q.size() != 0) begin
      chk("data", 64'(bus.out_data_o), 64'(m_q[0][31:0]));
      chk("last", 64'(bus.out_last_o), 64'(m_q[0][32]));
    end else begin
      chk("idle_data", 64'(bus.out_data_o), 64'h0);
      chk("idle_last", 64'(bus.out_last_o), 64'h0);
    end
    if (bus.out_valid_o && rdy && !clr) begin
      last_popped = bus.out_data_o;
      if (bus.out_last_o) last_vals.push_back(bus.out_data_o);
    end
    bus.psum_en_i   = en;
    bus.psum_i      = psum;
    bus.out_ready_i = rdy;
    clear_i         = clr;
    was_full = (m_q.size() == 8);
    m_pop    = (m_q.size() != 0) && rdy;
    if (clr) begin
      m_q.delete();
      m_tile = 0;
      m_ovf  = 1'b0;
    end else begin
      if (m_pop) dummy = m_q.pop_front();
      if (en) begin
        lst    = (m_tile == 15);
        m_tile = lst ? 0 : m_tile + 1;
        if (!was_full || m_pop) m_q.push_back({lst, m_relu(psum)});
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; m_tile = 0; m_ovf = 1'b0; last_popped = '0;
    rst = 1'b1; clear_i = 1'b0;
    bus.psum_en_i = 1'b0; bus.psum_i = '0; bus.out_ready_i = 1'b0;

    add(1, 32'h123, 1, 0, 1, 32'h123, 0, 1, 0, 0);
    add(0, 32'h0,   1, 0, 0, 32'h0,   0, 0, 0, 0);
    add(0, 32'h0,   0, 1, 0, 32'h0,   0, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      add(1, 32'(k), 0, 0, 1, 32'h1, 0, (k <= 8) ? k : 8, k >= 8, k >= 9);
    for (int j = 1; j <= 8; j++)
      add(0, 32'h0, 1, 0, j < 8, (j < 8) ? 32'(j + 1) : 32'h0, 0, 8 - j, 0, 1);
    for (int m = 1; m <= 6; m++)
      add(1, 32'h10 + 32'(m), 0, 0, 1, 32'h11, 0, m, 0, 1);
    for (int p = 1; p <= 6; p++)
      add(0, 32'h0, 1, 0, p < 6, (p < 6) ? 32'h11 + 32'(p) : 32'h0, p == 5, 6 - p, 0, 1);

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid_o), 64'h0);
    chk("rst_data", 64'(bus.out_data_o), 64'h0);
    chk("rst_last", 64'(bus.out_last_o), 64'h0);
    chk("rst_count", 64'(count_o), 64'h0);
    chk("rst_full", 64'(full_o), 64'h0);
    chk("rst_ovf", 64'(overflow_o), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].psum, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("row%0d valid", i), 64'(bus.out_valid_o), 64'(tbl[i].e_valid));
      chk($sformatf("row%0d data", i), 64'(bus.out_data_o), 64'(tbl[i].e_data));
      chk($sformatf("row%0d last", i), 64'(bus.out_last_o), 64'(tbl[i].e_last));
      chk($sformatf("row%0d count", i), 64'(count_o), 64'(tbl[i].e_count));
      chk($sformatf("row%0d full", i), 64'(full_o), 64'(tbl[i].e_full));
      chk($sformatf("row%0d ovf", i), 64'(overflow_o), 64'(tbl[i].e_ovf));
    end

    drive(1'b0, 32'h0, 1'b0, 1'b1);
    last_vals.delete();
    for (int v = 1; v <= 32; v++) drive(1'b1, 32'(v), 1'b1, 1'b0);
    idle(2);
    chk("tile_last_cnt", 64'(last_vals.size()), 64'd2);
    if (last_vals.size() == 2) begin
      chk("tile_last0", 64'(last_vals[0]), 64'd16);
      chk("tile_last1", 64'(last_vals[1]), 64'd32);
    end

    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int v = 1; v <= 8; v++) drive(1'b1, 32'h50 + 32'(v), 1'b0, 1'b0);
    drive(1'b1, 32'hAA, 1'b1, 1'b0);
    chk("pp_count", 64'(count_o), 64'd8);
    chk("pp_ovf", 64'(overflow_o), 64'h0);
    idle(9);
    chk("pp_last_pop", 64'(last_popped), 64'hAA);

    drive(1'b0, 32'h0, 1'b0, 1'b1);
    for (int v = 1; v <= 9; v++) drive(1'b1, 32'h60 + 32'(v), 1'b0, 1'b0);
    for (int v = 0; v < 3; v++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("clr_pre_count", 64'(count_o), 64'd5);
    chk("clr_pre_ovf", 64'(overflow_o), 64'h1);
    drive(1'b1, 32'h77, 1'b1, 1'b1);
    chk("clr_count", 64'(count_o), 64'h0);
    chk("clr_valid", 64'(bus.out_valid_o), 64'h0);
    chk("clr_ovf", 64'(overflow_o), 64'h0);
    last_vals.delete();
    for (int v = 1; v <= 16; v++) drive(1'b1, 32'h100 + 32'(v), 1'b1, 1'b0);
    idle(2);
    chk("clr_tile_cnt", 64'(last_vals.size()), 64'd1);
    if (last_vals.size() == 1) chk("clr_tile_val", 64'(last_vals[0]), 64'h110);

    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'hFFFF_FFF6, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0007, 1'b0, 1'b0);
`ifdef PSUM_COLLECT_RELU_EN
    chk("relu_neg", 64'(bus.out_data_o), 64'h0);
`else
    chk("relu_neg", 64'(bus.out_data_o), 64'hFFFF_FFF6);
`endif
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    chk("relu_pos", 64'(bus.out_data_o), 64'h7);
    idle(2);

    for (int v = 1; v <= 3; v++) drive(1'b1, 32'h200 + 32'(v), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.out_valid_o), 64'h0);
    chk("arst_data", 64'(bus.out_data_o), 64'h0);
    chk("arst_count", 64'(count_o), 64'h0);
    chk("arst_full", 64'(full_o), 64'h0);
    m_q.delete();
    m_tile = 0;
    m_ovf  = 1'b0;
    bus.psum_en_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    drive(1'b1, 32'h0000_0321, 1'b0, 1'b0);
    chk("arst_push_data", 64'(bus.out_data_o), 64'h321);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Drain endpoint at the bottom of one PE column. It receives the column's final partial sums on the PE psum/enable interface (psum value plus a 1-bit enable, no backpressure).
- Buffers the sums in a small FIFO and tags the last element of each tile.
- Presents the sums to the output-writeback path over a valid/ready handshake.
- This is the receiving end of the psum chain that the PE array transmits.

Parameters:
- PSUM_WIDTH, 32, width of each partial sum (two's complement).
- DEPTH, 8, FIFO entries; power of 2, ≥2.
- TILE_LEN, 16, psums per tile; ≥1.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- psum_i  input  PSUM_WIDTH  partial sum from last PE of column
- psum_en_i  input  1  psum_i valid this cycle; cannot be stalled
- clear_i  input  1  synchronous flush
- out_data_o  output  PSUM_WIDTH  head-of-FIFO psum
- out_last_o  output  1  head entry is last of its tile
- out_valid_o  output  1  FIFO non-empty
- out_ready_i  input  1  downstream accepts head this cycle
- count_o  output  $clog2(DEPTH)+1  current occupancy
- full_o  output  1  count_o == DEPTH
- overflow_o  output  1  sticky, psum dropped since last clear/reset

Behaviour:
- Reset (rst=1, async) forces the following:
  - wr_ptr, rd_ptr and count go to 0.
  - The tile counter goes to 0.
  - overflow_o, out_valid_o, out_last_o and full_o go to 0; count_o goes to 0.
  - out_data_o goes to 0. Memory contents are don't-care, but out_data_o is gated to 0 while empty.
- Storage: DEPTH × (PSUM_WIDTH+1) array. The extra bit holds the last flag.
- Pop:
  - pop = out_valid_o && out_ready_i.
  - rd_ptr advances mod DEPTH.
  - out_valid_o/out_data_o must not change while out_valid_o=1 and out_ready_i=0.
- Push:
  - push_req = psum_en_i && !clear_i.
  - The entry is written when count<DEPTH, or when count==DEPTH and pop happens in the same cycle (simultaneous push+pop at full is legal and count is unchanged).
  - Otherwise the entry is dropped and overflow_o is set on the next edge.
- Latency: psum_en_i=1 at edge N into an empty FIFO gives out_valid_o=1 and out_data_o=psum_i in the cycle after edge N (first-word-fall-through, 1 cycle).
- Count: +1 on write-only, −1 on pop-only, unchanged on both or neither.
- Tile counter:
  - Increments on every push_req, including dropped ones, so tile alignment survives overflow.
  - The last flag is written as 1 when the counter == TILE_LEN−1; the counter then wraps to 0.
  - If TILE_LEN=1, every entry is last.
- clear_i=1 (synchronous, at the edge) does the following:
  - Pointers, count, tile counter and overflow_o go to 0.
  - A pending pop is ignored; buffered data is discarded.
  - A psum_en_i in the same cycle is discarded.
  - The cycle after the edge shows out_valid_o=0.
- Reset mid-transfer: all state is lost immediately (async); no output pulses are generated on deassertion.
- Width: psum_i is stored unmodified except as described under Optional Feature. No arithmetic on data.

Optional Feature:
- Macro PSUM_COLLECT_RELU_EN.
- When defined: an entry whose MSB is 1 (negative) is written as 0; non-negative values are unchanged. This is applied at write time, so out_data_o never shows a negative value.
- When undefined: no clamp; psum_i is stored bit-exact.
- Tile tagging, flow control and overflow are identical in both builds.

Test Plan:
- Single push, empty FIFO: psum_i=0x0000_0123, psum_en_i=1 for 1 cycle, out_ready_i=1.
  - Next cycle: out_valid_o=1, out_data_o=0x123, count_o=1.
  - Following cycle: out_valid_o=0, count_o=0.
- Tile tagging, TILE_LEN=16: push 32 consecutive psums 1..32 with out_ready_i=1.
  - out_last_o=1 only on values 16 and 32.
- Fill and overflow, DEPTH=8, out_ready_i=0: push 10 values 1..10.
  - full_o=1 after the 8th push; count_o=8; overflow_o=1 after the 9th push.
  - Then drain with out_ready_i=1: exactly 1..8 come out.
  - The tile counter reached 10, so the next last flag is on the 6th subsequent push.
- Full with simultaneous push+pop: with count_o=8 and out_ready_i=1, push 0xAA.
  - Write accepted; count_o stays 8; overflow_o stays 0; 0xAA is the last value popped.
- Clear mid-stream: 5 entries buffered, overflow_o=1; pulse clear_i together with psum_en_i=1.
  - Next cycle: count_o=0, out_valid_o=0, overflow_o=0; the tile counter restarts at 0.
- RELU build: push 0xFFFF_FFF6 (−10) and 0x0000_0007.
  - Output is 0x0 then 0x7 with PSUM_COLLECT_RELU_EN defined.
  - Output is 0xFFFF_FFF6 then 0x7 without it.
